forex_update_sched: RTL and testbench
=====================================

// Module: forex_update_sched
// PURPOSE
//  Buffers edge-weight updates written by software over Avalon-MM and sequences the
//  arbitrage solver (Container): present edge, pulse solver reset/start, wait for done.
//  Sits between the HPS bus slave and the solver, replacing ad-hoc write-triggered kicks.
// PARAMETERS
//  PRED_W   `PRED_WIDTH+1    vertex index width (bits)
//  WEIGHT_W `WEIGHT_WIDTH+1  edge weight width (bits); also writedata width
//  DEPTH    8                update FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1            clock
//  reset        in   1            synchronous, active-high
//  chipselect   in   1            Avalon select
//  write        in   1            Avalon write strobe
//  read         in   1            Avalon read strobe
//  address      in   3            register index
//  writedata    in   WEIGHT_W     write data
//  readdata     out  32           status, valid the cycle after read&chipselect
//  upd_valid    out  1            edge presented to solver
//  upd_ready    in   1            solver accepted edge
//  upd_src      out  PRED_W       edge source vertex
//  upd_dst      out  PRED_W       edge dest vertex
//  upd_e        out  WEIGHT_W     edge weight
//  solver_reset out  1            one-cycle solver restart pulse
//  solver_done  in   1            solver finished current run (level or pulse)
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, upd_valid=0, readdata=0, overflow=0, staged src/dst=0;
//   solver_reset=1 while reset high, 0 first cycle after.
//  Regs: addr0 wr stages {src,dst}=writedata[2*PRED_W-1:PRED_W],[PRED_W-1:0];
//   addr1 wr pushes {staged src,dst,writedata}; addr2 wr clears overflow;
//   addr3 rd -> {overflow[31], busy[30], count[7:0]}; other addrs ignored, read 0.
//  Push when full: entry dropped, overflow sticky set. Push+pop same cycle when full:
//   pop frees slot first, push accepted, count unchanged.
//  Pointers wrap mod DEPTH; count is 0..DEPTH.
//  FSM: IDLE -(!empty)-> LOAD: upd_valid=1 with FIFO head; pop on upd_valid&upd_ready.
//   LOAD -(accepted)-> KICK: solver_reset=1 exactly one cycle -> SETTLE: one idle cycle
//   (solver samples) -> RUN: wait solver_done -> IDLE. busy = (state!=IDLE).
//  solver_done ignored outside RUN; done in SETTLE-exit cycle not missed (RUN checks level).
//  Upd outputs stable while upd_valid=1 and !upd_ready. Min latency push->solver_reset: 3 cycles.
//  Reset mid-run: FSM to IDLE, FIFO flushed, pending updates lost; solver_reset asserted.
// CONFIGURATION
//  FOREX_BATCH_EN defined: LOAD loops popping until FIFO empty (entries pushed meanwhile
//   included), then one KICK/SETTLE/RUN for the whole batch.
//  Undefined: one solver run per update (LOAD->KICK after each accepted edge).
// STRUCTURE
//  forex_pkg: sched_state_t enum {IDLE,LOAD,KICK,SETTLE,RUN}; edge_upd_t struct
//   {src,dst,e}; register address localparams REG_EDGE, REG_WEIGHT, REG_CLR, REG_STATUS.
//  Sub-module forex_upd_fifo (DEPTH x edge_upd_t, push/pop/full/empty/count).
// TESTING
//  Write addr0=(3<<PRED_W)|5, addr1=100, solver_done after 10 cycles -> upd 3->5 e=100,
//   one solver_reset pulse, busy clears 1 cycle after done.
//  Push 3 updates back-to-back; without FOREX_BATCH_EN -> 3 solver_reset pulses in FIFO order;
//   with -> 3 edges accepted then exactly 1 pulse.
//  Push DEPTH+2 with upd_ready=0 -> count=DEPTH, overflow=1; addr2 write -> overflow=0.
//  Hold upd_ready=0 for 5 cycles -> upd_src/dst/e stable, no pop, no solver_reset.
//  Assert reset during RUN with 4 queued -> next cycle state IDLE, count=0, upd_valid=0.
//  solver_done pulsed in IDLE/LOAD -> ignored; FSM still waits for done in RUN.

Source files
------------

// File: rtl/forex_pkg.sv
// forex_pkg: shared types and register map for the solver update scheduler.
// Widths follow PRED_WIDTH / WEIGHT_WIDTH when those are defined.
`ifndef PRED_WIDTH
`define PRED_WIDTH 3
`endif
`ifndef WEIGHT_WIDTH
`define WEIGHT_WIDTH 15
`endif

package forex_pkg;

  localparam int PRED_W = `PRED_WIDTH + 1;
  localparam int WEIGHT_W = `WEIGHT_WIDTH + 1;

  localparam logic [2:0] REG_EDGE   = 3'd0;
  localparam logic [2:0] REG_WEIGHT = 3'd1;
  localparam logic [2:0] REG_CLR    = 3'd2;
  localparam logic [2:0] REG_STATUS = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    SETTLE,
    RUN
  } sched_state_t;

  typedef struct packed {
    logic [PRED_W-1:0]   src;
    logic [PRED_W-1:0]   dst;
    logic [WEIGHT_W-1:0] e;
  } edge_upd_t;

  function automatic logic [31:0] status_word(
    input logic       ovf,
    input logic       busy,
    input logic [7:0] cnt
  );
    return {ovf, busy, 22'd0, cnt};
  endfunction

endpackage

// File: rtl/forex_upd_fifo.sv
// forex_upd_fifo: DEPTH-entry edge update queue.
// A pop frees its slot in time for a same-cycle push when full.
module forex_upd_fifo
  import forex_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  edge_upd_t                  i_data,
  input  logic                       i_pop,
  output edge_upd_t                  o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  edge_upd_t     r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/forex_update_sched.sv
// forex_update_sched: Avalon-fed edge update queue sequencing solver runs.
// FOREX_BATCH_EN: drain the whole queue per solver run instead of one edge.
module forex_update_sched
  import forex_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                chipselect,
  input  logic                write,
  input  logic                read,
  input  logic [2:0]          address,
  input  logic [WEIGHT_W-1:0] writedata,
  output logic [31:0]         readdata,
  output logic                upd_valid,
  input  logic                upd_ready,
  output logic [PRED_W-1:0]   upd_src,
  output logic [PRED_W-1:0]   upd_dst,
  output logic [WEIGHT_W-1:0] upd_e,
  output logic                solver_reset,
  input  logic                solver_done
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              w_wr;
  logic              w_rd;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic [CW-1:0]     w_count;
  edge_upd_t         w_in;
  edge_upd_t         w_head;
  logic [PRED_W-1:0] r_src;
  logic [PRED_W-1:0] r_dst;
  logic              r_ovf;
  logic [31:0]       r_rdata;
  sched_state_t      r_state;
  sched_state_t      w_next;

  assign w_wr   = chipselect & write;
  assign w_rd   = chipselect & read;
  assign w_push = w_wr & (address == REG_WEIGHT);
  assign w_pop  = upd_valid & upd_ready;
  assign w_drop = w_push & w_full & ~w_pop;
  assign w_in   = '{src: r_src, dst: r_dst, e: writedata};

  assign upd_src  = w_head.src;
  assign upd_dst  = w_head.dst;
  assign upd_e    = w_head.e;
  assign readdata = r_rdata;

  forex_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Stage the src/dst pair that the next weight write will carry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src <= '0;
      r_dst <= '0;
    end else if (w_wr && address == REG_EDGE) begin
      r_src <= writedata[2*PRED_W-1:PRED_W];
      r_dst <= writedata[PRED_W-1:0];
    end
  end

  // Sticky overflow: set by a dropped push, cleared by software.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_wr && address == REG_CLR) begin
      r_ovf <= 1'b0;
    end
  end

  // Registered status read; unmapped addresses and idle cycles read 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_rd && address == REG_STATUS) begin
      r_rdata <= status_word(r_ovf, r_state != IDLE, 8'(w_count));
    end else begin
      r_rdata <= '0;
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and solver-facing strobes.
  always_comb begin
    w_next       = r_state;
    upd_valid    = 1'b0;
    solver_reset = reset;
    unique case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_next = LOAD;
        end
      end
      LOAD: begin
        upd_valid = ~w_empty;
`ifdef FOREX_BATCH_EN
        if (w_empty) begin
          w_next = KICK;
        end
`else
        if (w_pop) begin
          w_next = KICK;
        end
`endif
      end
      KICK: begin
        solver_reset = 1'b1;
        w_next       = SETTLE;
      end
      SETTLE: begin
        w_next = RUN;
      end
      RUN: begin
        if (solver_done) begin
          w_next = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_forex_update_sched.sv
// tb_forex_update_sched: queue-based reference model with per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_forex_update_sched;
  import forex_pkg::*;

  localparam int D  = 8;
  localparam int PW = PRED_W;
  localparam int WW = WEIGHT_W;
  localparam int UW = 2 * PW + WW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          chipselect = 1'b0;
  logic          write = 1'b0;
  logic          read = 1'b0;
  logic [2:0]    address = '0;
  logic [WW-1:0] writedata = '0;
  logic [31:0]   readdata;
  logic          upd_valid;
  logic          upd_ready = 1'b0;
  logic [PW-1:0] upd_src;
  logic [PW-1:0] upd_dst;
  logic [WW-1:0] upd_e;
  logic          solver_reset;
  logic          solver_done = 1'b0;

  always #5 clk = ~clk;

  forex_update_sched #(.DEPTH(D)) dut (
    .clk          (clk),
    .reset        (reset),
    .chipselect   (chipselect),
    .write        (write),
    .read         (read),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata),
    .upd_valid    (upd_valid),
    .upd_ready    (upd_ready),
    .upd_src      (upd_src),
    .upd_dst      (upd_dst),
    .upd_e        (upd_e),
    .solver_reset (solver_reset),
    .solver_done  (solver_done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0 idle, 1 load, 2 kick, 3 settle, 4 run.
  logic [UW-1:0] mq[$];
  int            m_phase = 0;
  bit            m_ovf = 0;
  logic [PW-1:0] m_src = '0;
  logic [PW-1:0] m_dst = '0;
  logic [31:0]   m_rd = '0;
  bit            m_rd_chk = 0;
  bit            started = 0;

  always @(posedge clk) begin
    int n;
    bit pop;
    bit push;
    cyc++;
    if (reset) begin
      mq.delete();
      m_phase  = 0;
      m_ovf    = 0;
      m_src    = '0;
      m_dst    = '0;
      m_rd     = '0;
      m_rd_chk = 0;
      started  = 1;
    end else begin
      n        = mq.size();
      pop      = (m_phase == 1) && (n > 0) && upd_ready;
      push     = chipselect && write && address == 3'd1;
      m_rd_chk = chipselect && read;
      m_rd     = (m_rd_chk && address == 3'd3) ?
                 {m_ovf, (m_phase != 0), 22'd0, 8'(n)} : 32'd0;
      if (push) begin
        if (pop) void'(mq.pop_front());
        if (mq.size() < D) mq.push_back({m_src, m_dst, writedata});
        else m_ovf = 1;
      end else if (pop) begin
        void'(mq.pop_front());
      end
      if (chipselect && write && address == 3'd0)
        {m_src, m_dst} = writedata[2*PW-1:0];
      if (chipselect && write && address == 3'd2)
        m_ovf = 0;
      case (m_phase)
        0: if (n > 0) m_phase = 1;
`ifdef FOREX_BATCH_EN
        1: if (n == 0) m_phase = 2;
`else
        1: if (pop) m_phase = 2;
`endif
        2: m_phase = 3;
        3: m_phase = 4;
        4: if (solver_done) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  // Event log and solver stand-in.
  logic [UW-1:0] acc[$];
  int  n_pulse   = 0;
  int  pulse_cyc = -1;
  bit  armed     = 0;
  int  dcnt      = 0;
  int  done_delay = 10;
  bit  rmode     = 0;
  bit  rand_done = 0;
  logic ready_lvl = 1'b0;

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      bit ev;
      ev = (m_phase == 1) && (mq.size() > 0);
      chk("upd_valid", 64'(upd_valid), 64'(ev));
      if (ev) begin
        chk("upd_src", 64'(upd_src), 64'(mq[0][UW-1 -: PW]));
        chk("upd_dst", 64'(upd_dst), 64'(mq[0][WW+PW-1 -: PW]));
        chk("upd_e",   64'(upd_e),   64'(mq[0][WW-1:0]));
      end
      chk("solver_reset", 64'(solver_reset),
          64'(reset || m_phase == 2));
      if (m_rd_chk) chk("readdata", 64'(readdata), 64'(m_rd));
      if (!reset && upd_valid && upd_ready)
        acc.push_back({upd_src, upd_dst, upd_e});
      if (!reset && solver_reset) begin
        n_pulse++;
        if (pulse_cyc < 0) pulse_cyc = cyc;
        armed = 1;
        dcnt  = 0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    upd_ready   = rmode ? 1'($urandom_range(0, 1)) : ready_lvl;
    solver_done = 1'b0;
    if (armed) begin
      dcnt++;
      if (dcnt >= done_delay) begin
        solver_done = 1'b1;
        armed       = 0;
      end
    end
    if (rand_done && $urandom_range(0, 3) == 0) solver_done = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [WW-1:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    tick(1);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [31:0] v);
    chipselect = 1'b1;
    read       = 1'b1;
    address    = a;
    tick(1);
    chipselect = 1'b0;
    read       = 1'b0;
    v          = readdata;
  endtask

  task automatic push_upd(input int s, input int d, input int e);
    bus_wr(3'd0, WW'({PW'(s), PW'(d)}));
    bus_wr(3'd1, WW'(e));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (!(m_phase == 0 && mq.size() == 0) && k < budget) begin
      tick(1);
      k++;
    end
    n_tests++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s: drain timeout, phase %0d queued %0d",
               name, m_phase, mq.size());
    end
  endtask

  function automatic logic [UW-1:0] mk(input int s, input int d,
                                       input int e);
    return {PW'(s), PW'(d), WW'(e)};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]   st;
    logic [UW-1:0] snap;
    int            t0;
    int            p0;

    tick(3);
    chk("reset_readdata", 64'(readdata), 64'd0);
    chk("reset_upd_valid", 64'(upd_valid), 64'd0);
    chk("reset_solver_reset", 64'(solver_reset), 64'd1);
    reset = 1'b0;
    tick(1);
    chk("post_reset_solver_reset", 64'(solver_reset), 64'd0);

    // Single update end to end.
    ready_lvl  = 1'b1;
    done_delay = 10;
    acc.delete();
    n_pulse   = 0;
    pulse_cyc = -1;
    bus_wr(3'd0, WW'((3 << PW) | 5));
    t0 = cyc;
    bus_wr(3'd1, WW'(100));
    wait_idle(200, "single");
    chk("single_count", 64'(acc.size()), 64'd1);
    chk("single_edge", 64'(acc[0]), 64'(mk(3, 5, 100)));
    chk("single_pulses", 64'(n_pulse), 64'd1);
    chk("single_latency", 64'(pulse_cyc - t0), 64'd3);
    bus_rd(3'd3, st);
    chk("single_status", 64'(st), 64'd0);

    // Three queued updates released together.
    ready_lvl = 1'b0;
    acc.delete();
    n_pulse = 0;
    push_upd(1, 2, 11);
    push_upd(2, 3, 22);
    push_upd(3, 4, 33);
    tick(2);
    ready_lvl = 1'b1;
    wait_idle(400, "three");
    chk("three_count", 64'(acc.size()), 64'd3);
    chk("three_e0", 64'(acc[0]), 64'(mk(1, 2, 11)));
    chk("three_e1", 64'(acc[1]), 64'(mk(2, 3, 22)));
    chk("three_e2", 64'(acc[2]), 64'(mk(3, 4, 33)));
`ifdef FOREX_BATCH_EN
    chk("three_pulses", 64'(n_pulse), 64'd1);
`else
    chk("three_pulses", 64'(n_pulse), 64'd3);
`endif

    // Overflow with the solver stalled, then clear.
    ready_lvl = 1'b0;
    bus_wr(3'd0, WW'({PW'(7), PW'(6)}));
    for (int i = 0; i < D + 2; i++) bus_wr(3'd1, WW'(200 + i));
    bus_rd(3'd3, st);
    chk("ovf_status", 64'(st), 64'h0000_0000_C000_0008);
    bus_wr(3'd2, '0);
    bus_rd(3'd3, st);
    chk("ovf_clear_status", 64'(st), 64'h0000_0000_4000_0008);

    // Held handshake keeps the presented edge stable.
    snap = {upd_src, upd_dst, upd_e};
    p0   = n_pulse;
    tick(5);
    chk("hold_edge", 64'({upd_src, upd_dst, upd_e}), 64'(snap));
    chk("hold_edge_lit", 64'(snap), 64'(mk(7, 6, 200)));
    chk("hold_pulses", 64'(n_pulse), 64'(p0));
    bus_rd(3'd3, st);
    chk("hold_status", 64'(st), 64'h0000_0000_4000_0008);
    ready_lvl = 1'b1;
    wait_idle(2000, "ovf_drain");

    // Reset while the solver runs with four queued.
    done_delay = 60;
    push_upd(1, 1, 1);
    tick(6);
    for (int i = 0; i < 4; i++) push_upd(2, 2, 10 + i);
    bus_rd(3'd3, st);
    chk("run_status", 64'(st), 64'h0000_0000_4000_0004);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("midrun_upd_valid", 64'(upd_valid), 64'd0);
    bus_rd(3'd3, st);
    chk("midrun_status", 64'(st), 64'd0);

    // solver_done outside RUN must not advance the sequence.
    rand_done = 1;
    tick(20);
    ready_lvl = 1'b0;
    p0 = n_pulse;
    push_upd(9, 9, 9);
    tick(10);
    chk("done_ignored_pulses", 64'(n_pulse), 64'(p0));
    bus_rd(3'd3, st);
    chk("done_ignored_status", 64'(st), 64'h0000_0000_4000_0001);
    rand_done  = 0;
    armed      = 0;
    done_delay = 8;
    ready_lvl  = 1'b1;
    wait_idle(200, "done_ignored");
    chk("done_ignored_run", 64'(n_pulse), 64'(p0 + 1));

    // Randomized traffic.
    rmode     = 1;
    rand_done = 1;
    for (int i = 0; i < 1500; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 299) == 0) reset = 1'b1;
      if (op <= 4) begin
        chipselect = 1'b1;
        write      = 1'b1;
        address    = (op <= 3) ? 3'(op % 2) : 3'($urandom_range(0, 7));
        writedata  = WW'($urandom);
      end else if (op <= 6) begin
        chipselect = 1'b1;
        read       = 1'b1;
        address    = (op == 5) ? 3'd3 : 3'($urandom_range(0, 7));
      end else begin
        chipselect = 1'($urandom_range(0, 1));
      end
      tick(1);
      chipselect = 1'b0;
      write      = 1'b0;
      read       = 1'b0;
      reset      = 1'b0;
    end
    rmode     = 0;
    ready_lvl = 1'b1;
    wait_idle(4000, "random_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
